// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage core: stall, flush and bubble control for the PC and the
// pipeline registers, with wrong-path fetch discard, DMEM wait timeout and a stall counter.
module hazard_control_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       if_id_rs1_i,
    input  logic [4:0]       if_id_rs2_i,
    input  logic             if_id_use_rs1_i,
    input  logic             if_id_use_rs2_i,
    input  logic [4:0]       id_ex_rd_i,
    input  logic             id_ex_mem_re_i,
    input  logic             ex_redirect_i,
    input  logic             imem_ready_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_we_o,
    output logic             pc_sel_redirect_o,
    output logic             if_id_we_o,
    output logic             if_id_flush_o,
    output logic             id_ex_we_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_we_o,
    output logic             mem_wb_bubble_o,
    output logic             dmem_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {StRun, StDmemWait} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic             discard_q, discard_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic dmem_stall, load_use;
    logic pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble;

    assign dmem_stall = dmem_req_i & ~dmem_ready_i;
    assign load_use   = id_ex_mem_re_i & (id_ex_rd_i != 5'd0) &
                        ((if_id_use_rs1_i & (if_id_rs1_i == id_ex_rd_i)) |
                         (if_id_use_rs2_i & (if_id_rs2_i == id_ex_rd_i)));

    always_comb begin
        pc_we          = 1'b1;
        pc_sel         = 1'b0;
        if_id_we       = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_we       = 1'b1;
        id_ex_flush    = 1'b0;
        ex_mem_we      = 1'b1;
        mem_wb_bubble  = 1'b0;
        fsm_d          = StRun;
        discard_d      = discard_q;
        wait_cnt_d     = '0;
        timeout_d      = timeout_q;
        stall_cycles_d = stall_cycles_q;

        // A returning fetch always retires a pending discard, even under a DMEM freeze.
        if (discard_q && imem_ready_i) begin
            discard_d = 1'b0;
        end

        if (dmem_stall) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_we     = 1'b0;
            mem_wb_bubble = 1'b1;
            fsm_d         = StDmemWait;
            if (fsm_q == StRun) begin
                wait_cnt_d = WaitW'(1);
            end else begin
                wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
            end
            if (wait_cnt_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
                timeout_d = 1'b1;
            end
        end else if (ex_redirect_i) begin
            pc_sel      = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            discard_d   = ~imem_ready_i;
        end else if (discard_q) begin
            pc_we       = 1'b0;
            if_id_flush = 1'b1;
        end else if (load_use) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (!imem_ready_i) begin
            pc_we       = 1'b0;
            if_id_flush = 1'b1;
        end

        if (!pc_we && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q          <= StRun;
            discard_q      <= 1'b0;
            wait_cnt_q     <= '0;
            timeout_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            fsm_q          <= fsm_d;
            discard_q      <= discard_d;
            wait_cnt_q     <= wait_cnt_d;
            timeout_q      <= timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Reset forces the pipeline safe: nothing loads, every stage boundary holds a bubble.
    always_comb begin
        pc_we_o           = pc_we & ~rst_i;
        pc_sel_redirect_o = pc_sel & ~rst_i;
        if_id_we_o        = if_id_we & ~rst_i;
        if_id_flush_o     = if_id_flush | rst_i;
        id_ex_we_o        = id_ex_we & ~rst_i;
        id_ex_flush_o     = id_ex_flush | rst_i;
        ex_mem_we_o       = ex_mem_we & ~rst_i;
        mem_wb_bubble_o   = mem_wb_bubble | rst_i;
        dmem_timeout_o    = timeout_q & ~rst_i;
        stall_cycles_o    = stall_cycles_q;
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: hand-computed control vectors per cycle,
// stall counter tracked from the expected pc_we stream.
module tb_hazard_control_unit;

    localparam logic [7:0] Normal   = 8'b1010_1010;
    localparam logic [7:0] InReset  = 8'b0001_0101;
    localparam logic [7:0] LoadUse  = 8'b0000_1110;
    localparam logic [7:0] Redirect = 8'b1111_1110;
    localparam logic [7:0] FetchGap = 8'b0011_1010;
    localparam logic [7:0] DStall   = 8'b0000_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic        use_rs1, use_rs2, mem_re, redirect, imem_ready, dmem_req, dmem_ready;
    logic        pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we;
    logic        mem_wb_bubble, dmem_timeout;
    logic [31:0] stall_cycles;
    logic [7:0]  ctrl;

    int n_cmp = 0;
    int n_err = 0;
    int exp_stalls = 0;

    always #5 clk = ~clk;

    assign ctrl = {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we,
                   mem_wb_bubble};

    hazard_control_unit #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .if_id_rs1_i       (rs1),
        .if_id_rs2_i       (rs2),
        .if_id_use_rs1_i   (use_rs1),
        .if_id_use_rs2_i   (use_rs2),
        .id_ex_rd_i        (rd),
        .id_ex_mem_re_i    (mem_re),
        .ex_redirect_i     (redirect),
        .imem_ready_i      (imem_ready),
        .dmem_req_i        (dmem_req),
        .dmem_ready_i      (dmem_ready),
        .pc_we_o           (pc_we),
        .pc_sel_redirect_o (pc_sel),
        .if_id_we_o        (if_id_we),
        .if_id_flush_o     (if_id_flush),
        .id_ex_we_o        (id_ex_we),
        .id_ex_flush_o     (id_ex_flush),
        .ex_mem_we_o       (ex_mem_we),
        .mem_wb_bubble_o   (mem_wb_bubble),
        .dmem_timeout_o    (dmem_timeout),
        .stall_cycles_o    (stall_cycles)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rs1 = 5'd1; rs2 = 5'd2; rd = 5'd0;
        use_rs1 = 1'b0; use_rs2 = 1'b0; mem_re = 1'b0; redirect = 1'b0;
        imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    // Checks one cycle's control vector and the counter, then advances past the next edge.
    task automatic apply(input string tag, input logic [7:0] exp);
        #2;
        check_eq(tag, {24'd0, ctrl}, {24'd0, exp});
        check_eq({tag, "_cnt"}, stall_cycles, exp_stalls);
        if (!exp[7]) exp_stalls++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #2;
        check_eq("rst_ctrl", {24'd0, ctrl}, {24'd0, InReset});
        check_eq("rst_timeout", {31'd0, dmem_timeout}, 32'd0);
        check_eq("rst_cnt", stall_cycles, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        apply("idle", Normal);

        mem_re = 1'b1; rd = 5'd5; rs1 = 5'd5; use_rs1 = 1'b1;
        apply("lu_rs1", LoadUse);
        idle();
        apply("lu_after", Normal);

        mem_re = 1'b1; rd = 5'd0; rs1 = 5'd0; use_rs1 = 1'b1;
        apply("lu_x0", Normal);
        mem_re = 1'b1; rd = 5'd5; rs1 = 5'd5; use_rs1 = 1'b0; rs2 = 5'd3; use_rs2 = 1'b1;
        apply("lu_nouse", Normal);
        rs2 = 5'd5;
        apply("lu_rs2", LoadUse);
        idle();

        redirect = 1'b1;
        apply("redir_rdy", Redirect);
        redirect = 1'b0;
        apply("redir_nodisc", Normal);

        redirect = 1'b1; imem_ready = 1'b0;
        apply("redir_wait", Redirect);
        redirect = 1'b0;
        apply("disc_1", FetchGap);
        apply("disc_2", FetchGap);
        imem_ready = 1'b1;
        apply("disc_drop", FetchGap);
        apply("disc_done", Normal);

        imem_ready = 1'b0;
        apply("imem_gap", FetchGap);
        idle();

        dmem_req = 1'b1; dmem_ready = 1'b0; redirect = 1'b1;
        mem_re = 1'b1; rd = 5'd7; rs1 = 5'd7; use_rs1 = 1'b1;
        for (int i = 0; i < 4; i++) apply("dfreeze", DStall);
        check_eq("dfreeze_to", {31'd0, dmem_timeout}, 32'd0);
        dmem_ready = 1'b1;
        apply("drelease", Redirect);
        idle();
        apply("post_rel", Normal);

        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 7; i++) apply("to_wait", DStall);
        check_eq("to_before", {31'd0, dmem_timeout}, 32'd0);
        apply("to_8th", DStall);
        check_eq("to_set", {31'd0, dmem_timeout}, 32'd1);
        apply("to_hold", DStall);
        check_eq("to_hold", {31'd0, dmem_timeout}, 32'd1);
        idle();
        apply("to_release", Normal);
        check_eq("to_sticky", {31'd0, dmem_timeout}, 32'd1);

        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) apply("mid_wait", DStall);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ctrl", {24'd0, ctrl}, {24'd0, InReset});
        check_eq("mid_rst_to", {31'd0, dmem_timeout}, 32'd0);
        check_eq("mid_rst_cnt", stall_cycles, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_stalls = 0;
        for (int i = 0; i < 7; i++) apply("rewait", DStall);
        check_eq("rewait_to", {31'd0, dmem_timeout}, 32'd0);
        idle();
        apply("rewait_rel", Normal);

        redirect = 1'b1; imem_ready = 1'b0;
        apply("disc_rst_set", Redirect);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_stalls = 0;
        apply("disc_rst_gone", Normal);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
